// File: rtl/melody_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// melody_sequencer_pkg
// Shared definitions for the buzzer sequencing datapath:
//   - note word layout: {end, rest, dur[3:0], freq_ov[FREQ_W-1:0]}, with the
//     metadata offsets given relative to the top of the freq field
//   - sequencer state encoding
//   - board clock and default beat / gap lengths
//   - beat_product(): duration units * beat length, saturated to the timer width
// -----------------------------------------------------------------------------
package melody_sequencer_pkg;

    localparam int unsigned CLK_HZ              = 50_000_000;
    localparam int unsigned BEAT_CYCLES_DEFAULT = CLK_HZ / 4;   // 250 ms
    localparam int unsigned GAP_CYCLES_DEFAULT  = CLK_HZ / 50;  // 20 ms

    localparam int DUR_W   = 4;
    localparam int TIMER_W = 28;

    // Bit offsets above freq_ov inside a note word.
    localparam int DUR_OFS  = 0;
    localparam int REST_OFS = 4;
    localparam int END_OFS  = 5;
    localparam int META_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    // A zero duration plays as one unit; the product is clamped to all-ones
    // rather than wrapping when it does not fit the timer.
    function automatic logic [TIMER_W-1:0] beat_product(input logic [DUR_W-1:0] dur,
                                                        input logic [31:0]      beat);
        logic [DUR_W-1:0]    units;
        logic [DUR_W+31:0]   prod;
        units = (dur == '0) ? DUR_W'(1) : dur;
        prod  = (DUR_W+32)'(units) * (DUR_W+32)'(beat);
        if (prod > (DUR_W+32)'({TIMER_W{1'b1}}))
            beat_product = '1;
        else
            beat_product = prod[TIMER_W-1:0];
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// -----------------------------------------------------------------------------
// melody_sequencer_if
// Bundles the sequencer's buttons, note ROM port, tone divider controls and
// duration timer handshake.
//   master : the sequencer (drives rom_addr, tone_*, timer_ov/start, busy, song_done)
//   slave  : the environment (buttons, ROM, timer)
// -----------------------------------------------------------------------------
interface melody_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int FREQ_W = 28
);
    logic                                     play;
    logic                                     stop;
    logic [ADDR_W-1:0]                        rom_addr;
    logic [FREQ_W+melody_sequencer_pkg::META_W-1:0] rom_data;
    logic [FREQ_W-1:0]                        tone_ov;
    logic                                     tone_en;
    logic [melody_sequencer_pkg::TIMER_W-1:0] timer_ov;
    logic                                     timer_start;
    logic                                     timer_done;
    logic                                     busy;
    logic                                     song_done;

    modport master (
        input  play, stop, rom_data, timer_done,
        output rom_addr, tone_ov, tone_en, timer_ov, timer_start, busy, song_done
    );

    modport slave (
        output play, stop, rom_data, timer_done,
        input  rom_addr, tone_ov, tone_en, timer_ov, timer_start, busy, song_done
    );
endinterface

// File: rtl/melody_sequencer_btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Registered rising-edge detector for a button level already synchronous to clk.
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   level in  button level
//   pulse out one-cycle pulse, one cycle after the level rises
// -----------------------------------------------------------------------------
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);
    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Tracking the level during reset means a button already held when
            // reset releases is not seen as a fresh press.
            level_q <= level;
            pulse   <= 1'b0;
        end else begin
            // NOTE: non-blocking, so pulse compares the new level against the
            // previous cycle's level_q, not the value written on this edge.
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end
endmodule

// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
// Walks a synchronous note ROM and programs the tone divider and the duration
// timer for each note, with a muted articulation gap after every note.
//   clk, rst  board clock, synchronous active-high reset
//   bus       melody_sequencer_if.master:
//             play/stop (levels, rising edge acts), rom_addr/rom_data (1-cycle
//             ROM), tone_ov/tone_en (divider), timer_ov/timer_start/timer_done
//             (duration timer), busy, song_done
// -----------------------------------------------------------------------------
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int          ADDR_W      = 6,
    parameter int          FREQ_W      = 28,
    parameter int unsigned BEAT_CYCLES = BEAT_CYCLES_DEFAULT,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEFAULT,
    parameter bit          LOOP        = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    melody_sequencer_if.master bus
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic               play_p;
    logic               stop_p;

    logic               note_end;
    logic               note_rest;
    logic [DUR_W-1:0]   note_dur;
    logic [FREQ_W-1:0]  note_freq;

    assign note_end  = bus.rom_data[FREQ_W+END_OFS];
    assign note_rest = bus.rom_data[FREQ_W+REST_OFS];
    assign note_dur  = bus.rom_data[FREQ_W+DUR_OFS +: DUR_W];
    assign note_freq = bus.rom_data[FREQ_W-1:0];

    btn_edge u_play_edge (.clk(clk), .rst(rst), .level(bus.play), .pulse(play_p));
    btn_edge u_stop_edge (.clk(clk), .rst(rst), .level(bus.stop), .pulse(stop_p));

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            gap_cnt         <= '0;
            bus.rom_addr    <= '0;
            bus.tone_ov     <= '0;
            bus.tone_en     <= 1'b0;
            bus.timer_ov    <= '0;
            bus.timer_start <= 1'b0;
            bus.busy        <= 1'b0;
            bus.song_done   <= 1'b0;
        end else begin
            // Both strobes are single-cycle unless re-asserted below.
            bus.timer_start <= 1'b0;
            bus.song_done   <= 1'b0;

            // Stop overrides everything, including a simultaneous play.
            if (stop_p) begin
                state        <= ST_IDLE;
                bus.rom_addr <= '0;
                bus.tone_en  <= 1'b0;
                bus.busy     <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        bus.tone_en <= 1'b0;
                        if (play_p) begin
                            bus.rom_addr <= '0;
                            bus.busy     <= 1'b1;
                            state        <= ST_FETCH;
                        end
                    end
                    // rom_addr is held for one cycle so rom_data is valid in DECODE.
                    ST_FETCH: state <= ST_DECODE;
                    ST_DECODE: begin
                        if (note_end) begin
                            bus.song_done <= 1'b1;
                            bus.rom_addr  <= '0;
                            if (LOOP) begin
                                state <= ST_FETCH;
                            end else begin
                                bus.busy <= 1'b0;
                                state    <= ST_IDLE;
                            end
                        end else begin
                            bus.tone_ov     <= note_freq;
                            bus.timer_ov    <= beat_product(note_dur, BEAT_CYCLES);
                            bus.timer_start <= 1'b1;
                            bus.tone_en     <= ~note_rest;
                            state           <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (bus.timer_done) begin
                            bus.tone_en <= 1'b0;
                            gap_cnt     <= GAP_W'(GAP_CYCLES - 1);
                            state       <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == '0) begin
                            // Address wraps naturally at 2^ADDR_W.
                            bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
                            state        <= ST_FETCH;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
